// File: rtl/tag_mem_nway_wb_pkg.sv
// Shared types and width helpers for the N-way write-back tag store.
package tag_mem_nway_wb_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, PRESENT, DONE} flush_state_t;

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int plru_bits(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/tag_mem_nway_wb_plru_tree.sv
// Tree-PLRU for one set: picks the victim and computes the state after touching a way.
// Level l of the tree is steered by way bit l (LSB at the root); a node bit names the LRU side.
module tag_mem_nway_wb_plru_tree
    import tag_mem_nway_wb_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WAY_W = way_bits(WAYS),
    localparam int PLRU_W = plru_bits(WAYS)
) (
    input  logic [PLRU_W-1:0] state,
    input  logic [WAY_W-1:0]  touch_way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] next_state
);

    always_comb begin
        int pv, pt, nv, nt;
        victim = '0;
        next_state = state;
        pv = 0;
        pt = 0;
        for (int l = 0; l < WAY_W; l++) begin
            nv = (1 << l) - 1 + pv;
            nt = (1 << l) - 1 + pt;
            for (int n = 0; n < PLRU_W; n++) begin
                if (n == nv) victim[l] = state[n];
                if (n == nt) next_state[n] = ~touch_way[l];
            end
            pv = pv + (int'(victim[l]) << l);
            pt = pt + (int'(touch_way[l]) << l);
        end
    end

endmodule

// File: rtl/tag_mem_nway_wb.sv
// WAYS-way set-associative tag store with tree-PLRU replacement and a dirty-line flush engine.
module tag_mem_nway_wb
    import tag_mem_nway_wb_pkg::*;
#(
    parameter int TAG_WIDTH = 6,
    parameter int INDEX_WIDTH = 8,
    parameter int WAYS = 2,
    localparam int WAY_W = way_bits(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [TAG_WIDTH-1:0]   tagin,
    input  logic [WAY_W-1:0]       wr_way,
    input  logic                   dirty_wr,
    output logic                   hit,
    output logic [WAY_W-1:0]       hit_way,
    output logic [WAY_W-1:0]       victim_way,
    output logic                   victim_valid,
    output logic                   victim_dirty,
    output logic [TAG_WIDTH-1:0]   victim_tag,
    input  logic                   flush_req,
    output logic                   flush_busy,
    output logic                   flush_vld,
    output logic [INDEX_WIDTH-1:0] flush_index,
    output logic [WAY_W-1:0]       flush_way,
    output logic [TAG_WIDTH-1:0]   flush_tag,
    input  logic                   flush_ack,
    output logic                   flush_done
);

    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int PLRU_W = plru_bits(WAYS);

    logic [SETS-1:0][WAYS-1:0]   valid_q, dirty_q;
    logic [SETS-1:0][PLRU_W-1:0] plru_q;
    logic [TAG_WIDTH-1:0]        tag_mem [SETS][WAYS];

    flush_state_t                 state;
    logic [INDEX_WIDTH+WAY_W-1:0] cnt;
    logic [INDEX_WIDTH-1:0]       cnt_idx;
    logic [WAY_W-1:0]             cnt_way;
    logic                         line_dirty, last_line;

    logic             hit_raw, inv_any, active;
    logic [WAY_W-1:0] hit_way_raw, inv_way, plru_victim, victim_sel, touch_way;
    logic [PLRU_W-1:0] plru_next;

    assign cnt_idx    = cnt[WAY_W +: INDEX_WIDTH];
    assign cnt_way    = cnt[WAY_W-1:0];
    assign line_dirty = valid_q[cnt_idx][cnt_way] && dirty_q[cnt_idx][cnt_way];
    assign last_line  = &cnt;

    // Descending scan so the lowest-numbered match/invalid way wins.
    always_comb begin
        hit_raw = 1'b0;
        hit_way_raw = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[index][w] && tag_mem[index][w] == tagin) begin
                hit_raw = 1'b1;
                hit_way_raw = WAY_W'(w);
            end
            if (!valid_q[index][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign touch_way = wr ? wr_way : hit_way_raw;

    tag_mem_nway_wb_plru_tree #(.WAYS(WAYS)) u_plru (
        .state      (plru_q[index]),
        .touch_way  (touch_way),
        .victim     (plru_victim),
        .next_state (plru_next)
    );

    assign victim_sel   = inv_any ? inv_way : plru_victim;
    assign active       = rd && !flush_busy;
    assign hit          = active && hit_raw;
    assign hit_way      = hit ? hit_way_raw : '0;
    assign victim_way   = active ? victim_sel : '0;
    assign victim_valid = active && valid_q[index][victim_sel];
    assign victim_dirty = active && dirty_q[index][victim_sel];
    assign victim_tag   = active ? tag_mem[index][victim_sel] : '0;

    always_ff @(posedge clk) begin
        if (wr && !flush_busy) tag_mem[index][wr_way] <= tagin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            plru_q      <= '0;
            state       <= IDLE;
            cnt         <= '0;
            flush_busy  <= 1'b0;
            flush_vld   <= 1'b0;
            flush_done  <= 1'b0;
            flush_index <= '0;
            flush_way   <= '0;
            flush_tag   <= '0;
        end else begin
            flush_done <= 1'b0;
            if (!flush_busy) begin
                if (wr) begin
                    valid_q[index][wr_way] <= 1'b1;
                    dirty_q[index][wr_way] <= dirty_wr;
                    plru_q[index]          <= plru_next;
                end else if (rd && hit_raw) begin
                    plru_q[index] <= plru_next;
                end
            end
            case (state)
                IDLE: if (flush_req) begin
                    state      <= SCAN;
                    flush_busy <= 1'b1;
                    cnt        <= '0;
                end
                SCAN: if (line_dirty) begin
                    state       <= PRESENT;
                    flush_vld   <= 1'b1;
                    flush_index <= cnt_idx;
                    flush_way   <= cnt_way;
                    flush_tag   <= tag_mem[cnt_idx][cnt_way];
                end else begin
                    cnt <= cnt + 1'b1;
                    if (last_line) begin
                        state      <= DONE;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end
                end
                PRESENT: if (flush_ack) begin
                    dirty_q[cnt_idx][cnt_way] <= 1'b0;
                    flush_vld <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    if (last_line) begin
                        state      <= DONE;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end else begin
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_mem_nway_wb.sv
// Directed bench for the 4-way tag store: lookup and flush scoreboards drained by a negedge monitor.
module tb_tag_mem_nway_wb;

    logic       clk = 1'b0;
    logic       rst, rd, wr, dirty_wr, flush_req, flush_ack;
    logic [7:0] index;
    logic [5:0] tagin;
    logic [1:0] wr_way;
    logic       hit, victim_valid, victim_dirty, flush_busy, flush_vld, flush_done;
    logic [1:0] hit_way, victim_way, flush_way;
    logic [5:0] victim_tag, flush_tag;
    logic [7:0] flush_index;

    always #5 clk = ~clk;

    tag_mem_nway_wb #(.TAG_WIDTH(6), .INDEX_WIDTH(8), .WAYS(4)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .index(index), .tagin(tagin),
        .wr_way(wr_way), .dirty_wr(dirty_wr), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag), .flush_req(flush_req), .flush_busy(flush_busy),
        .flush_vld(flush_vld), .flush_index(flush_index), .flush_way(flush_way),
        .flush_tag(flush_tag), .flush_ack(flush_ack), .flush_done(flush_done)
    );

    typedef struct {
        logic       hit;
        logic [1:0] hw;
        logic [1:0] vw;
        logic       vv;
        logic       vd;
        logic [5:0] vt;
        logic       ct;
    } lk_exp_t;

    typedef struct {
        logic [7:0] idx;
        logic [1:0] way;
        logic [5:0] tag;
    } fl_exp_t;

    lk_exp_t lk_q[$];
    fl_exp_t fl_q[$];
    lk_exp_t le;
    fl_exp_t fcur;
    int      checks = 0;
    int      failures = 0;
    int      done_cnt = 0;
    logic    vld_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd) begin
            if (lk_q.size() == 0) begin
                check("lookup_unexpected", 32'd1, 32'd0);
            end else begin
                le = lk_q.pop_front();
                check("lookup_hit_victim", {hit, hit_way, victim_way, victim_valid, victim_dirty},
                      {le.hit, le.hw, le.vw, le.vv, le.vd});
                if (le.ct) check("lookup_victim_tag", 32'(victim_tag), 32'(le.vt));
            end
        end
        if (!rst && flush_vld) begin
            if (!vld_prev) begin
                if (fl_q.size() == 0) check("flush_unexpected", 32'd1, 32'd0);
                else fcur = fl_q.pop_front();
            end
            check("flush_line", {flush_index, flush_way, flush_tag}, {fcur.idx, fcur.way, fcur.tag});
        end
        if (!rst && flush_done) done_cnt++;
        vld_prev = rst ? 1'b0 : flush_vld;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int idx, input int tag, input int eh, input int ehw,
                          input int evw, input int evv, input int evd, input int evt, input int ct);
        lk_exp_t e;
        e.hit = 1'(eh); e.hw = 2'(ehw); e.vw = 2'(evw); e.vv = 1'(evv);
        e.vd = 1'(evd); e.vt = 6'(evt); e.ct = 1'(ct);
        lk_q.push_back(e);
        index = 8'(idx); tagin = 6'(tag); rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic write(input int idx, input int way, input int tag, input int d);
        index = 8'(idx); wr_way = 2'(way); tagin = 6'(tag); dirty_wr = 1'(d); wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic push_fl(input int idx, input int way, input int tag);
        fl_exp_t f;
        f.idx = 8'(idx); f.way = 2'(way); f.tag = 6'(tag);
        fl_q.push_back(f);
    endtask

    task automatic start_flush();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (flush_vld) ok = 1'b1;
        end
        if (!ok) check("wait_flush_vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (flush_done) seen = 1'b1;
        end
        if (!seen) check("wait_flush_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int d0, cycles;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; index = '0; tagin = '0; wr_way = '0;
        dirty_wr = 1'b0; flush_req = 1'b0; flush_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_flush_outputs", {flush_busy, flush_vld, flush_done}, 3'b000);
        step();

        // empty cache: miss, victim way 0 invalid
        lookup(5, 'h0A, 0, 0, 0, 0, 0, 0, 0);

        write(5, 0, 'h0A, 0);
        lookup(5, 'h0A, 1, 0, 1, 0, 0, 0, 0);
        lookup(5, 'h0B, 0, 0, 1, 0, 0, 0, 0);

        // full set: PLRU ordering
        for (int w = 0; w < 4; w++) write(3, w, 'h10 + w, 0);
        lookup(3, 'h10, 1, 0, 0, 1, 0, 'h10, 1);
        lookup(3, 'h11, 1, 1, 1, 1, 0, 'h11, 1);
        lookup(3, 'h12, 1, 2, 2, 1, 0, 'h12, 1);
        lookup(3, 'h3F, 0, 0, 3, 1, 0, 'h13, 1);
        lookup(3, 'h13, 1, 3, 3, 1, 0, 'h13, 1);
        lookup(3, 'h3F, 0, 0, 0, 1, 0, 'h10, 1);

        // two dirty lines flushed in scan order, acked after 3 cycles
        write(1, 1, 'h21, 1);
        write(200, 0, 'h22, 1);
        lookup(1, 'h21, 1, 1, 0, 0, 0, 0, 0);
        push_fl(1, 1, 'h21);
        push_fl(200, 0, 'h22);
        d0 = done_cnt;
        start_flush();
        for (int k = 0; k < 2; k++) begin
            wait_vld(ok);
            if (ok) begin
                repeat (3) step();
                flush_ack = 1'b1;
                step();
                flush_ack = 1'b0;
            end
        end
        wait_done();
        repeat (4) step();
        check("dirty_flush_done_count", 32'(done_cnt - d0), 32'd1);
        lookup(1, 'h21, 1, 1, 0, 0, 0, 0, 0);
        lookup(200, 'h22, 1, 0, 1, 0, 0, 0, 0);

        // clean cache: length of flush, lookups blocked while busy
        start_flush();
        index = 8'd3; tagin = 6'h10; rd = 1'b1;
        lk_q.push_back('{hit: 1'b0, hw: 2'd0, vw: 2'd0, vv: 1'b0, vd: 1'b0, vt: 6'd0, ct: 1'b1});
        @(negedge clk);
        check("clean_flush_busy_rise", 32'(flush_busy), 32'd1);
        cycles = 1;
        step();
        rd = 1'b0;
        while (cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (flush_done) break;
        end
        check("clean_flush_length", 32'(cycles), 32'd1025);
        check("clean_flush_busy_at_done", 32'(flush_busy), 32'd0);
        step();
        lookup(3, 'h3F, 0, 0, 0, 1, 0, 'h10, 1);

        // dirty victim, then reset in the middle of a presented line
        for (int w = 0; w < 4; w++) write(9, w, 'h30 + w, 1);
        lookup(9, 'h3E, 0, 0, 0, 1, 1, 'h30, 1);
        push_fl(9, 0, 'h30);
        d0 = done_cnt;
        start_flush();
        wait_vld(ok);
        step();
        step();
        #1 rst = 1'b1;
        #1 check("rst_abort_busy_vld", {flush_busy, flush_vld}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        lookup(9, 'h30, 0, 0, 0, 0, 0, 0, 0);
        lookup(5, 'h0A, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) step();
        check("rst_no_flush_done", 32'(done_cnt - d0), 32'd0);

        check("lookup_queue_drained", 32'(lk_q.size()), 32'd0);
        check("flush_queue_drained", 32'(fl_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
